count_sequencer: RTL and testbench

//  Sequences one single-pixel-imaging acquisition: decodes 16-bit SPI commands, waits for a DMD

---
 rtl/count_seq_pkg.sv | 27 ++
 rtl/count_sequencer_if.sv | 31 +++
 rtl/gate_timer.sv | 53 +++++
 rtl/count_sequencer.sv | 146 ++++++++++++++
 tb/tb_count_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/count_seq_pkg.sv
// Shared definitions for the acquisition sequencer: opcodes, field widths and FSM encoding.
package count_seq_pkg;

  localparam int CMD_W = 16;
  localparam int OPC_W = 4;
  localparam int ARG_W = 12;

  localparam logic [OPC_W-1:0] OP_STOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_START   = 4'h1;
  localparam logic [OPC_W-1:0] OP_SETGATE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ABORT   = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_COUNT  = 3'd3,
    ST_LATCH  = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  // A zero-length gate is meaningless, so it is promoted to one tick.
  function automatic logic [ARG_W-1:0] clamp_gate(input logic [ARG_W-1:0] arg);
    return (arg == '0) ? ARG_W'(1) : arg;
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Signal bundle between SPI slave / photon counter (master side) and the sequencer (slave side).
interface count_sequencer_if #(
  parameter int CNT_W = 32
);
  import count_seq_pkg::*;

  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             pat_trig;
  logic [CNT_W-1:0] count_in;
  logic             count_clr;
  logic             count_en;
  logic [CNT_W-1:0] data_out;
  logic             data_valid;
  logic             data_ack;
  logic             busy;
  logic             overrun;

  // data_valid stays high until a data_ack pulse; an ack in the first valid cycle is accepted,
  // and an ack while data_valid is low is ignored.
  modport master (
    output cmd, cmd_valid, pat_trig, count_in, data_ack,
    input  count_clr, count_en, data_out, data_valid, busy, overrun
  );

  modport slave (
    input  cmd, cmd_valid, pat_trig, count_in, data_ack,
    output count_clr, count_en, data_out, data_valid, busy, overrun
  );

endinterface

// File: rtl/gate_timer.sv
// Window timer: ticks * PRESCALE cycles (or ticks cycles in cycle mode), done on the last cycle.
module gate_timer
  import count_seq_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cycle_mode,
  input  logic [ARG_W-1:0] ticks,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(PRESCALE - 1);

  logic [PW-1:0]    presc_cnt;
  logic [ARG_W-1:0] tick_cnt;
  logic             running;
  logic             mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      tick_cnt  <= '0;
      running   <= 1'b0;
      mode      <= 1'b0;
    end else if (stop) begin
      running <= 1'b0;
    end else if (start) begin
      running   <= (ticks != '0);
      tick_cnt  <= ticks;
      presc_cnt <= cycle_mode ? '0 : PRESC_LOAD;
      mode      <= cycle_mode;
    end else if (running) begin
      if (presc_cnt == '0) begin
        if (tick_cnt <= ARG_W'(1)) begin
          running <= 1'b0;
        end else begin
          tick_cnt  <= tick_cnt - ARG_W'(1);
          presc_cnt <= mode ? '0 : PRESC_LOAD;
        end
      end else begin
        presc_cnt <= presc_cnt - PW'(1);
      end
    end
  end

  assign done = running && (presc_cnt == '0) && (tick_cnt == ARG_W'(1));

endmodule

// File: rtl/count_sequencer.sv
// Single-pixel-imaging acquisition sequencer: command decode, trigger wait, gated count, readout.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PRESCALE   = 100,
  parameter int SETTLE_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  count_sequencer_if.slave    bus,
  output state_t              dbg_state
);

  localparam logic [ARG_W-1:0] SETTLE_TICKS = ARG_W'(SETTLE_CYC);
  localparam logic             SETTLE_SKIP  = (SETTLE_CYC == 0);

  state_t state, next_state;

  logic [OPC_W-1:0] op;
  logic [ARG_W-1:0] arg;
  logic             cmd_stop, cmd_start, cmd_setgate, cmd_abort;

  logic             trig_q, trig_edge;
  logic [ARG_W-1:0] gate_len;
  logic [ARG_W-1:0] n_left;
  logic             free_run;
  logic             stop_pending;
  logic             overrun;
  logic             count_clr;
  logic [CNT_W-1:0] data_out;

  logic             tmr_start, tmr_cycle_mode, tmr_done;
  logic [ARG_W-1:0] tmr_ticks;
  logic             hold_exit;
  logic             last_sample;

  assign op          = bus.cmd[CMD_W-1 -: OPC_W];
  assign arg         = bus.cmd[ARG_W-1:0];
  assign cmd_stop    = bus.cmd_valid && (op == OP_STOP);
  assign cmd_start   = bus.cmd_valid && (op == OP_START);
  assign cmd_setgate = bus.cmd_valid && (op == OP_SETGATE);
  assign cmd_abort   = bus.cmd_valid && (op == OP_ABORT);
  assign last_sample = !free_run && (n_left == ARG_W'(1));

  gate_timer #(.PRESCALE(PRESCALE)) u_gate_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (tmr_start),
    .stop       (cmd_abort),
    .cycle_mode (tmr_cycle_mode),
    .ticks      (tmr_ticks),
    .done       (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state     = state;
    tmr_start      = 1'b0;
    tmr_cycle_mode = 1'b0;
    tmr_ticks      = gate_len;
    hold_exit      = 1'b0;
    if (cmd_abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (cmd_start) next_state = ST_ARM;
        ST_ARM: begin
          // No sample is in flight while armed, so STOP can leave at once.
          if (cmd_stop) begin
            next_state = ST_IDLE;
          end else if (trig_edge) begin
            next_state     = ST_SETTLE;
            tmr_start      = 1'b1;
            tmr_cycle_mode = 1'b1;
            tmr_ticks      = SETTLE_TICKS;
          end
        end
        ST_SETTLE: begin
          if (SETTLE_SKIP || tmr_done) begin
            next_state = ST_COUNT;
            tmr_start  = 1'b1;
          end
        end
        ST_COUNT:  if (tmr_done) next_state = ST_LATCH;
        ST_LATCH:  next_state = ST_HOLD;
        ST_HOLD: begin
          if (bus.data_ack) begin
            hold_exit  = 1'b1;
            next_state = (stop_pending || cmd_stop || last_sample) ? ST_IDLE : ST_ARM;
          end
        end
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q       <= 1'b0;
      trig_edge    <= 1'b0;
      gate_len     <= ARG_W'(1);
      n_left       <= '0;
      free_run     <= 1'b0;
      stop_pending <= 1'b0;
      overrun      <= 1'b0;
      count_clr    <= 1'b0;
      data_out     <= '0;
    end else begin
      trig_q    <= bus.pat_trig;
      trig_edge <= bus.pat_trig && !trig_q;
      count_clr <= (next_state == ST_SETTLE) && (state != ST_SETTLE);

      if (state == ST_LATCH) data_out <= bus.count_in;

      if (cmd_setgate && (state == ST_IDLE)) gate_len <= clamp_gate(arg);

      if (cmd_start && (state == ST_IDLE)) begin
        n_left   <= arg;
        free_run <= (arg == '0);
      end else if (hold_exit && !free_run) begin
        n_left <= n_left - ARG_W'(1);
      end

      if (next_state == ST_IDLE)               stop_pending <= 1'b0;
      else if (cmd_stop && state != ST_IDLE)   stop_pending <= 1'b1;

      // A stray edge is flagged and dropped; ABORT in the same cycle suppresses the flag.
      if (trig_edge && (state != ST_ARM) && !cmd_abort) overrun <= 1'b1;
      else if (cmd_start && (state == ST_IDLE))         overrun <= 1'b0;
    end
  end

  assign bus.count_clr  = count_clr;
  assign bus.count_en   = (state == ST_COUNT);
  assign bus.data_out   = data_out;
  assign bus.data_valid = (state == ST_HOLD);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.overrun    = overrun;
  assign dbg_state      = state;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: gate length, settle gap and latched samples per acquisition.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int CNT_W      = 32;
  localparam int PRESCALE   = 4;
  localparam int SETTLE_CYC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_sequencer_if #(.CNT_W(CNT_W)) bus ();
  state_t dbg_state;

  count_sequencer #(
    .CNT_W      (CNT_W),
    .PRESCALE   (PRESCALE),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_q[$];
  int n_samples = 0;
  int exp_gate = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Photon counter stand-in: advances by a random step each cycle.
  logic [CNT_W-1:0] count_src;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_src <= '0;
    else        count_src <= count_src + CNT_W'($urandom_range(1, 9));
  end
  assign bus.count_in = count_src;

  // Monitor: measures windows, pushes the expected sample at LATCH, pops on each new valid.
  logic prev_en = 1'b0;
  logic prev_valid = 1'b0;
  int run_len = 0;
  int since_clr = 100;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_en = 1'b0; prev_valid = 1'b0; run_len = 0; since_clr = 100;
    end else begin
      if (bus.count_clr) since_clr = 0;
      else if (since_clr < 100) since_clr++;
      if (bus.count_en) begin
        if (!prev_en) check("settle_gap", 32'(since_clr), 32'(SETTLE_CYC));
        run_len++;
      end else if (prev_en) begin
        check("gate_len", 32'(run_len), 32'(exp_gate));
        run_len = 0;
        exp_q.push_back(count_src);
      end
      if (bus.data_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("spurious_sample", 32'(bus.data_valid), 32'd0);
        else begin
          check("data_out", bus.data_out, exp_q.pop_front());
          n_samples++;
        end
      end
      prev_en = bus.count_en;
      prev_valid = bus.data_valid;
    end
  end

  task automatic send_cmd(input logic [3:0] op, input logic [11:0] arg);
    @(negedge clk);
    bus.cmd = {op, arg};
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    bus.pat_trig = 1'b1;
    repeat (3) @(negedge clk);
    bus.pat_trig = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.data_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.data_valid), 32'd1);
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!bus.count_en && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_count_en"}, 32'(bus.count_en), 32'd1);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.cmd = '0;
    bus.cmd_valid = 1'b0;
    bus.pat_trig = 1'b0;
    bus.data_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count_en", 32'(bus.count_en), 32'd0);
    check("rst_count_clr", 32'(bus.count_clr), 32'd0);
    check("rst_data_valid", 32'(bus.data_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Two-pattern run, 5 ticks of 4 cycles each.
    send_cmd(OP_SETGATE, 12'd5);
    exp_gate = 5 * PRESCALE;
    send_cmd(OP_START, 12'd2);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_state", 32'(dbg_state), 32'(ST_ARM));
    repeat (2) @(negedge clk);
    pulse_trig();
    wait_valid("a1");
    ack();
    pulse_trig();
    wait_valid("a2");
    ack();
    repeat (3) @(negedge clk);
    check("a_idle_busy", 32'(bus.busy), 32'd0);
    check("a_samples", 32'(n_samples), 32'd2);

    // Free-run, STOP during the third window.
    base = n_samples;
    send_cmd(OP_START, 12'd0);
    for (int i = 0; i < 2; i++) begin
      pulse_trig();
      wait_valid("fr");
      ack();
    end
    pulse_trig();
    wait_en("fr3");
    send_cmd(OP_STOP, 12'd0);
    check("fr_stop_still_busy", 32'(bus.busy), 32'd1);
    wait_valid("fr3");
    ack();
    repeat (3) @(negedge clk);
    check("fr_idle_busy", 32'(bus.busy), 32'd0);
    check("fr_samples", 32'(n_samples - base), 32'd3);

    // Trigger while holding an unread sample.
    send_cmd(OP_SETGATE, 12'd1);
    exp_gate = PRESCALE;
    send_cmd(OP_START, 12'd2);
    ack();
    check("ack_ignored_state", 32'(dbg_state), 32'(ST_ARM));
    base = n_samples;
    pulse_trig();
    wait_valid("ov");
    pulse_trig();
    repeat (2) @(negedge clk);
    check("ov_overrun", 32'(bus.overrun), 32'd1);
    check("ov_hold_state", 32'(dbg_state), 32'(ST_HOLD));
    ack();
    repeat (30) @(negedge clk);
    check("ov_back_to_arm", 32'(dbg_state), 32'(ST_ARM));
    check("ov_no_extra", 32'(n_samples - base), 32'd1);
    send_cmd(OP_ABORT, 12'd0);
    check("ov_abort_idle", 32'(bus.busy), 32'd0);
    check("ov_sticky", 32'(bus.overrun), 32'd1);
    send_cmd(OP_START, 12'd1);
    check("ov_cleared", 32'(bus.overrun), 32'd0);

    // ABORT while a sample is waiting.
    pulse_trig();
    wait_valid("ab");
    send_cmd(OP_ABORT, 12'd0);
    check("ab_valid", 32'(bus.data_valid), 32'd0);
    check("ab_count_en", 32'(bus.count_en), 32'd0);
    check("ab_state", 32'(dbg_state), 32'(ST_IDLE));

    // Zero gate promoted to one tick; SETGATE while busy leaves it alone.
    send_cmd(OP_SETGATE, 12'd0);
    exp_gate = PRESCALE;
    send_cmd(OP_START, 12'd1);
    send_cmd(OP_SETGATE, 12'd7);
    pulse_trig();
    wait_valid("g0");
    ack();
    repeat (3) @(negedge clk);
    check("g0_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of a counting window.
    send_cmd(OP_SETGATE, 12'd5);
    exp_gate = 5 * PRESCALE;
    send_cmd(OP_START, 12'd1);
    pulse_trig();
    wait_en("rs");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rs_count_en", 32'(bus.count_en), 32'd0);
    check("rs_busy", 32'(bus.busy), 32'd0);
    check("rs_valid", 32'(bus.data_valid), 32'd0);
    check("rs_data_out", bus.data_out, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_after_busy", 32'(bus.busy), 32'd0);
    check("rs_after_state", 32'(dbg_state), 32'(ST_IDLE));

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
